sd_init_sequencer: RTL and testbench
====================================

# sd_init_sequencer

SPI-mode SD card initialisation sequencer. Sits above the single-command SPI engine (which owns sdclk, mosi, miso, chip select and the 80-clock wake-up) and drives it through the full power-up sequence: CMD0, CMD8, the CMD55/ACMD41 polling loop, CMD58 and CMD16. It reports card ready, card capacity class, or a coded failure. The block then hands the engine over to the sector-read logic.

## Interface
- RETRY_LIMIT, 1000: max ACMD41 attempts before failure (counter 16 bits).
- RETRY_GAP, 27000: clk cycles idled between ACMD41 attempts (1 ms at 27 MHz; counter 32 bits).
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- init_start  in  1  pulse: begin initialisation; ignored while busy.
- cmd_start  out  1  one-cycle pulse to engine: send command.
- cmd_index  out  6  command number.
- cmd_arg  out  32  command argument.
- cmd_crc  out  7  CRC7 field.
- cmd_long  out  1  0 = R1 (8-bit) response; 1 = R3/R7 (40-bit).
- cmd_done  in  1  pulse: engine finished; cmd_response valid this cycle.
- cmd_timeout  in  1  qualifies cmd_done: no response start bit.
- cmd_response  in  40  right-justified; R1 in [7:0] (short) or [39:32] (long), payload [31:0].
- busy  out  1  sequence in progress.
- ready  out  1  init succeeded; sticky until next init_start/rst.
- error  out  1  init failed; sticky until next init_start/rst.
- error_code  out  3  failure cause, valid while error.
- is_sdhc  out  1  OCR CCS bit; valid while ready.

## Operation
- Reset values: all outputs 0. State IDLE. Retry and gap counters 0.
- States: IDLE, CMD0, W0, CMD8, W8, CMD55, W55, CMD41, W41, GAP, CMD58, W58, CMD16, W16, DONE, FAIL.
- Each CMDx state drives the command fields, pulses cmd_start once, then moves to Wx next cycle. Fields hold stable until cmd_done.
- Command fields, written as index/arg/crc/long:
  - CMD0: 0/0/0x4A/0.
  - CMD8: 8/0x000001AA/0x43/1.
  - CMD55: 55/0/0x7F/0.
  - CMD41: 41/(v2 ? 0x40000000 : 0)/0x7F/0.
  - CMD58: 58/0/0x7F/1.
  - CMD16: 16/0x00000200/0x7F/0.
- Any cmd_done with cmd_timeout=1 goes to FAIL with code 5.
- W0: R1==0x01 goes to CMD8; otherwise FAIL with code 1.
- W8:
  - R1 bit2 set (illegal command): card is v1, clear v2, go to CMD55.
  - R1==0x01 and response[11:0]==0x1AA: set v2, go to CMD55.
  - Otherwise: FAIL with code 2.
- W55: R1 bits[7:1] nonzero goes to FAIL with code 3; otherwise CMD41.
- W41:
  - R1==0x00: go to CMD58 if v2, else CMD16.
  - R1==0x01: increment retry counter. If it reaches RETRY_LIMIT, FAIL with code 3. Otherwise go to GAP.
  - Any other R1: FAIL with code 3.
- GAP: count RETRY_GAP cycles, then CMD55.
- W58:
  - R1 not 0x00: FAIL with code 4.
  - Otherwise latch is_sdhc=response[30]. Go to DONE if it is 1, else CMD16.
- W16: R1==0x00 goes to DONE; otherwise FAIL with code 6.
- DONE: ready=1, busy=0. FAIL: error=1, busy=0, error_code latched.
- init_start in IDLE/DONE/FAIL:
  - Clears ready, error, error_code, is_sdhc and the retry counter.
  - Sets busy and enters CMD0.
- cmd_done outside a Wx state is ignored.

## Timing
- init_start at cycle N: busy=1 at N+1, first cmd_start at N+1 (CMD0 state), W0 at N+2.
- cmd_done at cycle M in Wx: next state at M+1. The next cmd_start is at M+1 when that state is a CMDx state.
- GAP entered at cycle G: CMD55 entered at G+RETRY_GAP; cmd_start in that cycle.
- ready/error assert and busy deasserts in the cycle DONE/FAIL is entered. All outputs are registered.
- Only one cmd_start can occur per engine transaction; none while in Wx.
- rst mid-sequence (including during GAP or with cmd_done in the same cycle): rst wins. All outputs are 0 next cycle, no cmd_start.
- init_start and cmd_done in the same cycle while busy: init_start ignored, cmd_done processed.

## Test plan
- SDHC card:
  - Stimulus: responses 0x01; 0x01_000001AA; then 0x01 twice for CMD55/ACMD41; then 0x00/0x00; then CMD58 0x00_C0FF8000.
  - Required: ready=1, is_sdhc=1, no CMD16 issued. The first ACMD41 has arg 0x40000000. The two ACMD41 attempts are separated by RETRY_GAP cycles.
- v1 card:
  - Stimulus: CMD8 returns R1=0x05.
  - Required: CMD41 arg 0, no CMD58; CMD16 with arg 0x200 answered 0x00 ends with ready=1, is_sdhc=0.
- CMD8 echo mismatch:
  - Stimulus: CMD8 returns 0x01_000001AB.
  - Required: error=1, error_code=2, no further cmd_start.
- Retry exhaustion:
  - Stimulus: RETRY_LIMIT=3, ACMD41 always returns 0x01.
  - Required: exactly 3 CMD41 issued, then error_code=3.
- Timeout:
  - Stimulus: CMD0 cmd_done with cmd_timeout=1.
  - Required: error_code=5.
  - Follow-up: a subsequent init_start clears error and reissues CMD0.
- Reset during GAP:
  - Stimulus: rst pulsed while in GAP.
  - Required: all outputs 0, no cmd_start until the next init_start.

Source files
------------

// File: rtl/sd_init_sequencer_if.sv
// Command bus between the SD init sequencer (master) and the single-command
// SPI engine (slave) that actually shifts the command and response bits.
interface sd_init_sequencer_if;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        cmd_long;
    logic        cmd_done;
    logic        cmd_timeout;
    logic [39:0] cmd_response;

    modport master (
        output cmd_start,
        output cmd_index,
        output cmd_arg,
        output cmd_crc,
        output cmd_long,
        input  cmd_done,
        input  cmd_timeout,
        input  cmd_response
    );

    modport slave (
        input  cmd_start,
        input  cmd_index,
        input  cmd_arg,
        input  cmd_crc,
        input  cmd_long,
        output cmd_done,
        output cmd_timeout,
        output cmd_response
    );
endinterface

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card power-up sequencer: walks the command engine through CMD0,
// CMD8, the CMD55/ACMD41 polling loop, CMD58 and CMD16, then reports the result.
module sd_init_sequencer #(
    parameter int RETRY_LIMIT = 1000,
    parameter int RETRY_GAP   = 27000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_start,
    sd_init_sequencer_if.master  cmd,
    output logic                 busy,
    output logic                 ready,
    output logic                 error,
    output logic [2:0]           error_code,
    output logic                 is_sdhc
);

    typedef enum logic [3:0] {
        IDLE,
        CMD0,
        W0,
        CMD8,
        W8,
        CMD55,
        W55,
        CMD41,
        W41,
        GAP,
        CMD58,
        W58,
        CMD16,
        W16,
        DONE,
        FAIL
    } state_t;

    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        long_rsp;
    } cmd_fields_t;

    localparam logic [15:0] RETRY_LIMIT_W = 16'(RETRY_LIMIT);
    localparam logic [31:0] GAP_LAST      = 32'(RETRY_GAP - 1);

    localparam logic [2:0] ERR_CMD0    = 3'd1;
    localparam logic [2:0] ERR_CMD8    = 3'd2;
    localparam logic [2:0] ERR_ACMD41  = 3'd3;
    localparam logic [2:0] ERR_CMD58   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;
    localparam logic [2:0] ERR_CMD16   = 3'd6;

    state_t      state;
    logic        v2;
    logic [15:0] retry_cnt;
    logic [31:0] gap_cnt;
    cmd_fields_t fields_q;
    logic        start_q;

    logic [7:0]  r1_short;
    logic [7:0]  r1_long;
    logic [15:0] retry_inc;
    logic        unused_rsp;

    // Command field table; ACMD41 advertises HCS only to cards that passed CMD8.
    function automatic cmd_fields_t fields_for(state_t s, logic card_v2);
        cmd_fields_t f;
        f = '0;
        case (s)
            CMD0: begin
                f.index    = 6'd0;
                f.arg      = 32'h0000_0000;
                f.crc      = 7'h4A;
                f.long_rsp = 1'b0;
            end
            CMD8: begin
                f.index    = 6'd8;
                f.arg      = 32'h0000_01AA;
                f.crc      = 7'h43;
                f.long_rsp = 1'b1;
            end
            CMD55: begin
                f.index    = 6'd55;
                f.arg      = 32'h0000_0000;
                f.crc      = 7'h7F;
                f.long_rsp = 1'b0;
            end
            CMD41: begin
                f.index    = 6'd41;
                f.arg      = card_v2 ? 32'h4000_0000 : 32'h0000_0000;
                f.crc      = 7'h7F;
                f.long_rsp = 1'b0;
            end
            CMD58: begin
                f.index    = 6'd58;
                f.arg      = 32'h0000_0000;
                f.crc      = 7'h7F;
                f.long_rsp = 1'b1;
            end
            CMD16: begin
                f.index    = 6'd16;
                f.arg      = 32'h0000_0200;
                f.crc      = 7'h7F;
                f.long_rsp = 1'b0;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    assign r1_short  = cmd.cmd_response[7:0];
    assign r1_long   = cmd.cmd_response[39:32];
    assign retry_inc = retry_cnt + 16'd1;

    // OCR/echo bits the sequencer has no use for.
    assign unused_rsp = ^{cmd.cmd_response[31], cmd.cmd_response[29:12]};

    assign cmd.cmd_start = start_q;
    assign cmd.cmd_index = fields_q.index;
    assign cmd.cmd_arg   = fields_q.arg;
    assign cmd.cmd_crc   = fields_q.crc;
    assign cmd.cmd_long  = fields_q.long_rsp;

    // Single registered FSM: every transition into a CMDx state loads the
    // command fields and raises cmd_start for exactly that one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            v2         <= 1'b0;
            retry_cnt  <= '0;
            gap_cnt    <= '0;
            fields_q   <= '0;
            start_q    <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            error      <= 1'b0;
            error_code <= '0;
            is_sdhc    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE, DONE, FAIL: begin
                    if (init_start) begin
                        ready      <= 1'b0;
                        error      <= 1'b0;
                        error_code <= '0;
                        is_sdhc    <= 1'b0;
                        retry_cnt  <= '0;
                        v2         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= CMD0;
                        fields_q   <= fields_for(CMD0, 1'b0);
                        start_q    <= 1'b1;
                    end
                end
                CMD0:  state <= W0;
                CMD8:  state <= W8;
                CMD55: state <= W55;
                CMD41: state <= W41;
                CMD58: state <= W58;
                CMD16: state <= W16;
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= '0;
                        state    <= CMD55;
                        fields_q <= fields_for(CMD55, v2);
                        start_q  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                W0, W8, W55, W41, W58, W16: begin
                    if (cmd.cmd_done) begin
                        if (cmd.cmd_timeout) begin
                            state      <= FAIL;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                            error_code <= ERR_TIMEOUT;
                        end else begin
                            case (state)
                                W0: begin
                                    if (r1_short == 8'h01) begin
                                        state    <= CMD8;
                                        fields_q <= fields_for(CMD8, v2);
                                        start_q  <= 1'b1;
                                    end else begin
                                        state      <= FAIL;
                                        busy       <= 1'b0;
                                        error      <= 1'b1;
                                        error_code <= ERR_CMD0;
                                    end
                                end
                                W8: begin
                                    // Illegal-command on CMD8 marks a v1 card, not a failure.
                                    if (r1_long[2]) begin
                                        v2       <= 1'b0;
                                        state    <= CMD55;
                                        fields_q <= fields_for(CMD55, 1'b0);
                                        start_q  <= 1'b1;
                                    end else if (r1_long == 8'h01 &&
                                                 cmd.cmd_response[11:0] == 12'h1AA) begin
                                        v2       <= 1'b1;
                                        state    <= CMD55;
                                        fields_q <= fields_for(CMD55, 1'b1);
                                        start_q  <= 1'b1;
                                    end else begin
                                        state      <= FAIL;
                                        busy       <= 1'b0;
                                        error      <= 1'b1;
                                        error_code <= ERR_CMD8;
                                    end
                                end
                                W55: begin
                                    if (r1_short[7:1] != 7'd0) begin
                                        state      <= FAIL;
                                        busy       <= 1'b0;
                                        error      <= 1'b1;
                                        error_code <= ERR_ACMD41;
                                    end else begin
                                        state    <= CMD41;
                                        fields_q <= fields_for(CMD41, v2);
                                        start_q  <= 1'b1;
                                    end
                                end
                                W41: begin
                                    if (r1_short == 8'h00) begin
                                        state    <= v2 ? CMD58 : CMD16;
                                        fields_q <= fields_for(v2 ? CMD58 : CMD16, v2);
                                        start_q  <= 1'b1;
                                    end else if (r1_short == 8'h01) begin
                                        retry_cnt <= retry_inc;
                                        if (retry_inc == RETRY_LIMIT_W) begin
                                            state      <= FAIL;
                                            busy       <= 1'b0;
                                            error      <= 1'b1;
                                            error_code <= ERR_ACMD41;
                                        end else begin
                                            state   <= GAP;
                                            gap_cnt <= '0;
                                        end
                                    end else begin
                                        state      <= FAIL;
                                        busy       <= 1'b0;
                                        error      <= 1'b1;
                                        error_code <= ERR_ACMD41;
                                    end
                                end
                                W58: begin
                                    if (r1_long != 8'h00) begin
                                        state      <= FAIL;
                                        busy       <= 1'b0;
                                        error      <= 1'b1;
                                        error_code <= ERR_CMD58;
                                    end else begin
                                        // High-capacity cards are block addressed already; skip CMD16.
                                        is_sdhc <= cmd.cmd_response[30];
                                        if (cmd.cmd_response[30]) begin
                                            state <= DONE;
                                            busy  <= 1'b0;
                                            ready <= 1'b1;
                                        end else begin
                                            state    <= CMD16;
                                            fields_q <= fields_for(CMD16, v2);
                                            start_q  <= 1'b1;
                                        end
                                    end
                                end
                                W16: begin
                                    if (r1_short == 8'h00) begin
                                        state <= DONE;
                                        busy  <= 1'b0;
                                        ready <= 1'b1;
                                    end else begin
                                        state      <= FAIL;
                                        busy       <= 1'b0;
                                        error      <= 1'b1;
                                        error_code <= ERR_CMD16;
                                    end
                                end
                                default: state <= state;
                            endcase
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer: a table of engine transactions per card
// scenario, with hand-computed command fields, latencies and final status.
module tb_sd_init_sequencer;

    localparam int LIMIT       = 3;
    localparam int GAP         = 10;
    localparam int WAIT_BUDGET = 200;

    localparam logic [45:0] F_CMD0  = {6'd0,  32'h0000_0000, 7'h4A, 1'b0};
    localparam logic [45:0] F_CMD8  = {6'd8,  32'h0000_01AA, 7'h43, 1'b1};
    localparam logic [45:0] F_CMD55 = {6'd55, 32'h0000_0000, 7'h7F, 1'b0};
    localparam logic [45:0] F_A41V2 = {6'd41, 32'h4000_0000, 7'h7F, 1'b0};
    localparam logic [45:0] F_A41V1 = {6'd41, 32'h0000_0000, 7'h7F, 1'b0};
    localparam logic [45:0] F_CMD58 = {6'd58, 32'h0000_0000, 7'h7F, 1'b1};
    localparam logic [45:0] F_CMD16 = {6'd16, 32'h0000_0200, 7'h7F, 1'b0};

    // Status word {busy, ready, error, error_code, is_sdhc}
    localparam logic [6:0] ST_BUSY   = 7'b1000000;
    localparam logic [6:0] ST_SDHC   = 7'b0100001;
    localparam logic [6:0] ST_SDSC   = 7'b0100000;
    localparam logic [6:0] ST_E_CMD0 = 7'b0010010;
    localparam logic [6:0] ST_E_CMD8 = 7'b0010100;
    localparam logic [6:0] ST_E_A41  = 7'b0010110;
    localparam logic [6:0] ST_E_C58  = 7'b0011000;
    localparam logic [6:0] ST_E_TMO  = 7'b0011010;
    localparam logic [6:0] ST_E_C16  = 7'b0011100;

    logic       clk;
    logic       rst;
    logic       init_start;
    logic       busy;
    logic       ready;
    logic       error;
    logic [2:0] error_code;
    logic       is_sdhc;

    sd_init_sequencer_if bus();

    sd_init_sequencer #(
        .RETRY_LIMIT(LIMIT),
        .RETRY_GAP  (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_start(init_start),
        .cmd       (bus),
        .busy      (busy),
        .ready     (ready),
        .error     (error),
        .error_code(error_code),
        .is_sdhc   (is_sdhc)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [45:0] fields;
        int          lat;
        logic [39:0] resp;
        logic        tmo;
        logic        also_init;
    } step_t;

    typedef struct {
        int         first;
        int         count;
        logic [6:0] final_status;
    } scen_t;

    step_t steps[$];
    scen_t scens[$];

    function automatic step_t mk(logic [45:0] f, int lat, logic [39:0] resp,
                                 logic tmo, logic also_init);
        step_t s;
        s.fields    = f;
        s.lat       = lat;
        s.resp      = resp;
        s.tmo       = tmo;
        s.also_init = also_init;
        return s;
    endfunction

    function automatic logic [6:0] status_now();
        return {busy, ready, error, error_code, is_sdhc};
    endfunction

    function automatic logic [45:0] fields_now();
        return {bus.cmd_index, bus.cmd_arg, bus.cmd_crc, bus.cmd_long};
    endfunction

    task automatic check_output(string name, logic [63:0] actual, logic [63:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        init_start      = 1'b0;
        bus.cmd_done    = 1'b0;
        bus.cmd_timeout = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        do begin
            idle_cycle();
            lat++;
        end while (bus.cmd_start !== 1'b1 && lat < WAIT_BUDGET);
    endtask

    task automatic count_starts(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            idle_cycle();
            if (bus.cmd_start === 1'b1) n++;
        end
    endtask

    // Plays the engine for each step: check the issued command, then answer it.
    task automatic apply_stimulus(input int first, input int count, input string tag);
        int lat;
        for (int i = first; i < first + count; i++) begin
            wait_start(lat);
            check_output($sformatf("%s.%0d cmd_start", tag, i - first), 64'(bus.cmd_start), 64'(1'b1));
            check_output($sformatf("%s.%0d latency", tag, i - first), 64'(lat), 64'(steps[i].lat));
            check_output($sformatf("%s.%0d fields", tag, i - first), 64'(fields_now()), 64'(steps[i].fields));
            if (i == first)
                check_output($sformatf("%s busy_status", tag), 64'(status_now()), 64'(ST_BUSY));
            idle_cycle();
            check_output($sformatf("%s.%0d single_pulse", tag, i - first), 64'(bus.cmd_start), 64'(1'b0));
            idle_cycle();
            bus.cmd_done     = 1'b1;
            bus.cmd_response = steps[i].resp;
            bus.cmd_timeout  = steps[i].tmo;
            init_start       = steps[i].also_init;
        end
    endtask

    task automatic run_scenario(input int s);
        int    n;
        string tag;
        tag = $sformatf("scen%0d", s);
        idle_cycle();
        init_start = 1'b1;
        apply_stimulus(scens[s].first, scens[s].count, tag);
        idle_cycle();
        check_output({tag, " final_status"}, 64'(status_now()), 64'(scens[s].final_status));
        count_starts(GAP + 5, n);
        check_output({tag, " extra_starts"}, 64'(n), 64'(0));
        check_output({tag, " sticky_status"}, 64'(status_now()), 64'(scens[s].final_status));
    endtask

    initial begin
        int f0;
        int n;

        rst              = 1'b1;
        init_start       = 1'b0;
        bus.cmd_done     = 1'b0;
        bus.cmd_timeout  = 1'b0;
        bus.cmd_response = '0;

        // SDHC card, one ACMD41 retry with the inter-attempt gap
        f0 = steps.size();
        steps.push_back(mk(F_CMD0,  1,       40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8,  1,       40'h01_0000_01AA, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, 1,       40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1,       40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, GAP + 1, 40'h00_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1,       40'h00_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD58, 1,       40'h00_C0FF_8000, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_SDHC});

        // v1 card; init_start arrives alongside a cmd_done and must be ignored
        f0 = steps.size();
        steps.push_back(mk(F_CMD0,  1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8,  1, 40'h05_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, 1, 40'h00_0000_0001, 1'b0, 1'b1));
        steps.push_back(mk(F_A41V1, 1, 40'h00_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD16, 1, 40'h00_0000_0000, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_SDSC});

        // CMD8 echo pattern mismatch
        f0 = steps.size();
        steps.push_back(mk(F_CMD0, 1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8, 1, 40'h01_0000_01AB, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_CMD8});

        // ACMD41 never leaves idle: exactly LIMIT attempts
        f0 = steps.size();
        steps.push_back(mk(F_CMD0,  1,       40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8,  1,       40'h01_0000_01AA, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, 1,       40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1,       40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, GAP + 1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1,       40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, GAP + 1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1,       40'h00_0000_0001, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_A41});

        // CMD0 timeout, then a fresh init that must clear the error
        f0 = steps.size();
        steps.push_back(mk(F_CMD0, 1, 40'h00_0000_0001, 1'b1, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_TMO});

        f0 = steps.size();
        steps.push_back(mk(F_CMD0, 1, 40'h00_0000_0000, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_CMD0});

        // CMD58 R1 error
        f0 = steps.size();
        steps.push_back(mk(F_CMD0,  1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8,  1, 40'h01_0000_01AA, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, 1, 40'h00_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1, 40'h00_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD58, 1, 40'h04_0000_0000, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_C58});

        // v2 standard-capacity card whose CMD16 is rejected
        f0 = steps.size();
        steps.push_back(mk(F_CMD0,  1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8,  1, 40'h01_0000_01AA, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, 1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1, 40'h00_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD58, 1, 40'h00_80FF_8000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD16, 1, 40'h00_0000_0004, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_C16});

        // CMD55 reports an error bit
        f0 = steps.size();
        steps.push_back(mk(F_CMD0,  1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8,  1, 40'h05_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, 1, 40'h00_0000_0005, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_A41});

        // ACMD41 answers something other than 0x00/0x01
        f0 = steps.size();
        steps.push_back(mk(F_CMD0,  1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8,  1, 40'h01_0000_01AA, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, 1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1, 40'h00_0000_0005, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_A41});

        // CMD8 with R1=0x00 is neither v1 nor a valid v2 answer
        f0 = steps.size();
        steps.push_back(mk(F_CMD0, 1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8, 1, 40'h00_0000_01AA, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_E_CMD8});

        // v2 standard-capacity card that completes through CMD16
        f0 = steps.size();
        steps.push_back(mk(F_CMD0,  1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD8,  1, 40'h01_0000_01AA, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD55, 1, 40'h00_0000_0001, 1'b0, 1'b0));
        steps.push_back(mk(F_A41V2, 1, 40'h00_0000_0000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD58, 1, 40'h00_80FF_8000, 1'b0, 1'b0));
        steps.push_back(mk(F_CMD16, 1, 40'h00_0000_0000, 1'b0, 1'b0));
        scens.push_back('{f0, steps.size() - f0, ST_SDSC});

        $display("[TB] %0d scenarios, %0d engine steps", scens.size(), steps.size());

        repeat (3) idle_cycle();
        check_output("reset status", 64'(status_now()), 64'(0));
        check_output("reset fields", 64'(fields_now()), 64'(0));
        check_output("reset cmd_start", 64'(bus.cmd_start), 64'(0));
        rst = 1'b0;

        // A stray cmd_done while idle must not wake the sequencer
        idle_cycle();
        bus.cmd_done     = 1'b1;
        bus.cmd_response = 40'h00_0000_0001;
        count_starts(5, n);
        check_output("idle cmd_done starts", 64'(n), 64'(0));
        check_output("idle cmd_done status", 64'(status_now()), 64'(0));

        for (int s = 0; s < scens.size(); s++) run_scenario(s);

        // Reset in the middle of the ACMD41 retry gap
        idle_cycle();
        init_start = 1'b1;
        apply_stimulus(scens[0].first, 4, "gap_rst");
        repeat (4) idle_cycle();
        rst = 1'b1;
        idle_cycle();
        check_output("gap_rst status", 64'(status_now()), 64'(0));
        check_output("gap_rst fields", 64'(fields_now()), 64'(0));
        check_output("gap_rst cmd_start", 64'(bus.cmd_start), 64'(0));
        rst = 1'b0;
        count_starts(GAP + 15, n);
        check_output("gap_rst extra_starts", 64'(n), 64'(0));
        check_output("gap_rst idle_status", 64'(status_now()), 64'(0));

        run_scenario(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
